// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// FSM state encoding and the iteration-counter width helper.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the iteration counter for a k-bit multiplier (counts 0..k-1).
    function automatic int count_w(input int k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/partIII.sv
// K-bit ripple-carry adder built from a chain of full adders.
// Produces the unsigned sum and carry-out, plus a signed-overflow flag.
module partIII #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         carry_in,
    output logic [K-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    logic [K:0] carry;

    assign carry[0] = carry_in;

    // One full adder per bit; the carry ripples from bit 0 upward.
    for (genvar i = 0; i < K; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[K];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow  = carry[K] ^ carry[K-1];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned KxK -> 2K multiplier. A single partIII adder is
// reused every cycle: one conditional add of the multiplicand into the high
// half, then a right shift of {carry, hi, lo}. K steps per product.
module shift_add_mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [K-1:0]   a,
    input  logic [K-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*K-1:0] product,
    output logic           overflow_indicator
);

    localparam int                  COUNT_W = count_w(K);
    localparam logic [COUNT_W-1:0]  LAST    = COUNT_W'(K - 1);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               finish;

    logic [K-1:0]       mcand;
    logic [K-1:0]       hi;
    logic [K-1:0]       lo;
    logic [COUNT_W-1:0] count;

    logic [K-1:0]       addend;
    logic [K-1:0]       sum;
    logic               carry;
    logic [2*K-1:0]     shifted;

    // The current multiplier bit selects whether the multiplicand is added.
    assign addend  = lo[0] ? mcand : '0;
    assign shifted = {carry, sum, lo[K-1:1]};
    assign busy    = (state != IDLE);

    // The adder's signed overflow has no meaning for unsigned products.
    partIII #(.K(K)) u_adder (
        .a         (hi),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry),
        .overflow  ()
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath registers: capture operands, iterate, publish the result.
    always_ff @(posedge clk) begin
        // NOTE: every register here is plain flops (no RAM), so all of them
        // are cleared on reset; a mid-run reset leaves no partial residue.
        if (reset) begin
            mcand              <= '0;
            hi                 <= '0;
            lo                 <= '0;
            count              <= '0;
            product            <= '0;
            overflow_indicator <= 1'b0;
            done               <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, matching the hardware's simultaneous update.
            done <= finish;
            if (load) begin
                mcand <= a;
                lo    <= b;
                hi    <= '0;
                count <= '0;
            end
            if (step) begin
                {hi, lo} <= shifted;
                if (!finish) count <= count + COUNT_W'(1);
            end
            if (finish) begin
                product            <= shifted;
                overflow_indicator <= |shifted[2*K-1:K];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl (K=8). Expected products come
// from plain integer multiplication of the operands captured at acceptance.
module tb_shift_add_mult_ctrl;

    localparam int K = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [K-1:0]   a;
    logic [K-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*K-1:0] product;
    logic           overflow_indicator;

    int total;
    int bad;

    shift_add_mult_ctrl #(.K(K)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .a                  (a),
        .b                  (b),
        .busy               (busy),
        .done               (done),
        .product            (product),
        .overflow_indicator (overflow_indicator)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 0);
    endtask

    // Wait for done, counting edges; n = -1 if it never comes.
    task automatic wait_done(output int n, input bit scramble);
        n = 0;
        while (!done && n < 40) begin
            if (scramble) begin
                a = K'($urandom);
                b = K'($urandom);
            end
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    // One complete operation with latency, busy, result and hold checks.
    task automatic do_op(input logic [K-1:0] x, input logic [K-1:0] y, input bit scramble);
        int             n;
        logic [2*K-1:0] exp;
        logic [2*K-1:0] prev;
        exp  = (2*K)'(x) * (2*K)'(y);
        wait_idle();
        prev  = product;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("product_held_in_run", 32'(product), 32'(prev));
        wait_done(n, scramble);
        check("latency", 32'(n), K);
        check("busy_at_done", 32'(busy), 1);
        check("product", 32'(product), 32'(exp));
        check("overflow", 32'(overflow_indicator), 32'(exp > 16'd255));
        tick();
        check("done_pulse_width", 32'(done), 0);
        check("busy_cleared", 32'(busy), 0);
        check("product_held_after", 32'(product), 32'(exp));
    endtask

    initial begin
        int n;
        int gap;
        int dones;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        check("rst_overflow", 32'(overflow_indicator), 0);

        // Directed cases, including the extremes.
        do_op(8'd13, 8'd11, 1'b0);
        do_op(8'd255, 8'd255, 1'b0);
        do_op(8'd16, 8'd16, 1'b0);
        do_op(8'd0, 8'd200, 1'b0);
        do_op(8'd1, 8'd255, 1'b0);
        do_op(8'd255, 8'd0, 1'b0);

        // A start during RUN must be ignored.
        a = 8'd3; b = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd7; b = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, 1'b0);
        check("ignored_start_latency", 32'(n), K - 3);
        check("ignored_start_product", 32'(product), 15);
        tick();
        do_op(8'd7, 8'd7, 1'b0);

        // Start held high: completions every K+2 cycles.
        wait_idle();
        a = 8'd5; b = 8'd9; start = 1'b1;
        wait_done(n, 1'b0);
        check("held_first_done", 32'(n >= 0), 1);
        tick();
        wait_done(gap, 1'b0);
        check("held_period", 32'(gap + 1), K + 2);
        check("held_product", 32'(product), 45);
        start = 1'b0;
        tick();
        wait_idle();

        // Reset in the 4th RUN cycle discards the operation.
        a = 8'd200; b = 8'd100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_product", 32'(product), 0);
        check("midrst_overflow", 32'(overflow_indicator), 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 0);
        do_op(8'd2, 8'd3, 1'b0);

        // Random operands, inputs scrambled while the operation runs.
        for (int i = 0; i < 150; i++) begin
            do_op(K'($urandom), K'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
